reg_feed_fifo: RTL and testbench

REG_FEED_FIFO -- requirements
Module: reg_feed_fifo

---
 rtl/reg_feed_fifo_pkg.sv | 11 +
 rtl/reg_feed_fifo_if.sv | 29 ++
 rtl/reg_feed_fifo_mem.sv | 28 ++
 rtl/reg_feed_fifo.sv | 79 +++++++
 tb/tb_reg_feed_fifo.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/reg_feed_fifo_pkg.sv
// Shared defaults and derived widths for the register-feed FIFO slice.
package reg_feed_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 4;
    localparam int PTR_W     = $clog2(DEPTH_DEF);
    localparam int CNT_W     = PTR_W + 1;

    typedef logic [WIDTH_DEF-1:0] data_t;

endpackage

// File: rtl/reg_feed_fifo_if.sv
// Push/pop handshake bundle between a producer and the register-feed FIFO.
interface reg_feed_fifo_if
    import reg_feed_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
);
    localparam int IF_CNT_W = $clog2(DEPTH) + 1;

    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    in_data;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out_data;
    logic [IF_CNT_W-1:0] count;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );

endinterface

// File: rtl/reg_feed_fifo_mem.sv
// Entry storage: one synchronous write port, one asynchronous read port, no reset.
module reg_feed_mem
    import reg_feed_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write the addressed entry on an accepted push.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/reg_feed_fifo.sv
// First-word fall-through FIFO feeding a downstream enabled register; holds
// pointer/occupancy control, storage lives in reg_feed_mem.
module reg_feed_fifo
    import reg_feed_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic           clk,
    input  logic           rst,
    reg_feed_fifo_if.slave bus
);

    localparam int P_W = $clog2(DEPTH);
    localparam int C_W = P_W + 1;
    localparam logic [C_W-1:0] DEPTH_C = C_W'(DEPTH);

    logic [P_W-1:0]   wr_ptr_r;
    logic [P_W-1:0]   rd_ptr_r;
    logic [C_W-1:0]   count_r;
    logic             push_s;
    logic             pop_s;
    logic             in_ready_s;
    logic             out_valid_s;
    logic [WIDTH-1:0] rd_data_s;

    // Handshake qualification; ready/valid depend only on occupancy and rst.
    always_comb begin
        in_ready_s  = (count_r != DEPTH_C) && !rst;
        out_valid_s = (count_r != {C_W{1'b0}});
        push_s      = bus.in_valid  && in_ready_s  && !bus.flush;
        pop_s       = bus.out_ready && out_valid_s && !bus.flush;
    end

    // Pointer and occupancy state; flush overrides any push/pop that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {P_W{1'b0}};
            rd_ptr_r <= {P_W{1'b0}};
            count_r  <= {C_W{1'b0}};
        end else if (bus.flush) begin
            wr_ptr_r <= {P_W{1'b0}};
            rd_ptr_r <= {P_W{1'b0}};
            count_r  <= {C_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + P_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + P_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + C_W'(1);
                2'b01:   count_r <= count_r - C_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    reg_feed_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (P_W)
    ) u_mem (
        .clk   (clk),
        .we    (push_s),
        .waddr (wr_ptr_r),
        .wdata (bus.in_data),
        .raddr (rd_ptr_r),
        .rdata (rd_data_s)
    );

    // Zero the head when empty so stale storage never reaches the register.
    assign bus.out_data  = out_valid_s ? rd_data_s : {WIDTH{1'b0}};
    assign bus.out_valid = out_valid_s;
    assign bus.in_ready  = in_ready_s;
    assign bus.count     = count_r;

endmodule

// File: tb/tb_reg_feed_fifo.sv
// Scoreboard bench for reg_feed_fifo with a queue reference model and a
// second instance compared cycle by cycle.
module tb_reg_feed_fifo;
    import reg_feed_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    reg_feed_fifo_if #(.WIDTH(32), .DEPTH(DEPTH)) ifa ();
    reg_feed_fifo_if #(.WIDTH(32), .DEPTH(DEPTH)) ifb ();

    reg_feed_fifo #(.WIDTH(32), .DEPTH(DEPTH)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    reg_feed_fifo #(.WIDTH(32), .DEPTH(DEPTH)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    int    m_count = 0;
    data_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic v, input data_t d, input logic r, input logic f);
        ifa.in_valid = v; ifa.in_data = d; ifa.out_ready = r; ifa.flush = f;
        ifb.in_valid = v; ifb.in_data = d; ifb.out_ready = r; ifb.flush = f;
    endtask

    // Apply one cycle of stimulus, predict the outcome, and advance past the edge.
    task automatic drive(input logic v, input data_t d, input logic r, input logic f);
        bit acc;
        bit pp;
        set_in(v, d, r, f);
        acc = v && (m_count < DEPTH) && !f;
        pp  = r && (m_count > 0) && !f;
        if (f) exp_q.delete();
        else if (acc) exp_q.push_back(d);
        @(posedge clk); #1;
        if (f) m_count = 0;
        else   m_count = m_count + int'(acc) - int'(pp);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    // Monitor: compare outputs against the model and pop the scoreboard on each pop.
    always @(negedge clk) begin
        data_t e;
        chk("count",     64'(ifa.count), 64'(m_count));
        chk("out_valid", 64'(ifa.out_valid), 64'(m_count != 0));
        chk("in_ready",  64'(ifa.in_ready), 64'((m_count < DEPTH) && !rst));
        if (!ifa.out_valid) chk("out_data_zero", 64'(ifa.out_data), 64'h0);
        if (ifa.out_valid && ifa.out_ready && !ifa.flush && !rst) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 64'(ifa.out_data), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("order", 64'(ifa.out_data), 64'(e));
            end
        end
        chk("miter_data",  64'(ifb.out_data),  64'(ifa.out_data));
        chk("miter_valid", 64'(ifb.out_valid), 64'(ifa.out_valid));
        chk("miter_count", 64'(ifb.count),     64'(ifa.count));
    end

    initial begin
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("rst_count", 64'(ifa.count), 64'h0);
        chk("rst_valid", 64'(ifa.out_valid), 64'h0);
        chk("rst_ready", 64'(ifa.in_ready), 64'h0);
        chk("rst_data",  64'(ifa.out_data), 64'h0);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 64'(ifa.in_ready), 64'h1);

        // Fill to full with out_ready low.
        for (int i = 1; i <= 4; i++) drive(1'b1, 32'hA5A5_0000 + 32'(i), 1'b0, 1'b0);
        chk("full_count", 64'(ifa.count), 64'h4);
        chk("full_ready", 64'(ifa.in_ready), 64'h0);
        chk("full_head",  64'(ifa.out_data), 64'hA5A5_0001);

        // From full: pop-only, then push+pop, then drain (order 1..5).
        drive(1'b1, 32'h0000_0005, 1'b1, 1'b0);
        chk("pop_from_full", 64'(ifa.count), 64'h3);
        chk("ready_rises",   64'(ifa.in_ready), 64'h1);
        drive(1'b1, 32'h0000_0005, 1'b1, 1'b0);
        chk("push_pop_count", 64'(ifa.count), 64'h3);
        drain();

        // Ten words streamed through with simultaneous push/pop (pointer wrap).
        drive(1'b1, 32'h1000_0000, 1'b0, 1'b0);
        for (int i = 1; i < 10; i++) drive(1'b1, 32'h1000_0000 + 32'(i), 1'b1, 1'b0);
        chk("stream_count", 64'(ifa.count), 64'h1);
        drain();

        // Flush with count=2 overrides push and pop.
        drive(1'b1, 32'h2000_0001, 1'b0, 1'b0);
        drive(1'b1, 32'h2000_0002, 1'b0, 1'b0);
        drive(1'b1, 32'h2000_0003, 1'b1, 1'b1);
        chk("flush_count", 64'(ifa.count), 64'h0);
        chk("flush_valid", 64'(ifa.out_valid), 64'h0);
        chk("flush_data",  64'(ifa.out_data), 64'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset between edges with three entries stored.
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h3000_0000 + 32'(i), 1'b0, 1'b0);
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        m_count = 0;
        exp_q.delete();
        #1;
        chk("arst_count", 64'(ifa.count), 64'h0);
        chk("arst_valid", 64'(ifa.out_valid), 64'h0);
        chk("arst_data",  64'(ifa.out_data), 64'h0);
        chk("arst_ready", 64'(ifa.in_ready), 64'h0);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("arst_release_ready", 64'(ifa.in_ready), 64'h1);
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("post_rst_count", 64'(ifa.count), 64'h1);
        chk("post_rst_head",  64'(ifa.out_data), 64'hDEAD_BEEF);
        drain();

        // Random traffic with occasional flush.
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 1)), data_t'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 29) == 0));
        end
        drain();
        chk("sb_empty_at_end", 64'(exp_q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
